// File: rtl/axi_lite_slave_bridge_if.sv
// AXI4-Lite slave-side bus bundle for axi_lite_slave_bridge.
// slave: bridge side (i_* in, o_* out); master: interconnect side.
interface axi_lite_slave_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] i_axi_awaddr;
  logic                  i_axi_awvalid;
  logic                  o_axi_awready;
  logic [DATA_WIDTH-1:0] i_axi_wdata;
  logic [STRB_W-1:0]     i_axi_wstrb;
  logic                  i_axi_wvalid;
  logic                  o_axi_wready;
  logic [1:0]            o_axi_bresp;
  logic                  o_axi_bvalid;
  logic                  i_axi_bready;
  logic [ADDR_WIDTH-1:0] i_axi_araddr;
  logic                  i_axi_arvalid;
  logic                  o_axi_arready;
  logic [DATA_WIDTH-1:0] o_axi_rdata;
  logic [1:0]            o_axi_rresp;
  logic                  o_axi_rvalid;
  logic                  i_axi_rready;

  modport slave (
    input  i_axi_awaddr, i_axi_awvalid,
    output o_axi_awready,
    input  i_axi_wdata, i_axi_wstrb, i_axi_wvalid,
    output o_axi_wready,
    output o_axi_bresp, o_axi_bvalid,
    input  i_axi_bready,
    input  i_axi_araddr, i_axi_arvalid,
    output o_axi_arready,
    output o_axi_rdata, o_axi_rresp, o_axi_rvalid,
    input  i_axi_rready
  );

  modport master (
    output i_axi_awaddr, i_axi_awvalid,
    input  o_axi_awready,
    output i_axi_wdata, i_axi_wstrb, i_axi_wvalid,
    input  o_axi_wready,
    input  o_axi_bresp, o_axi_bvalid,
    output i_axi_bready,
    output i_axi_araddr, i_axi_arvalid,
    input  o_axi_arready,
    input  o_axi_rdata, o_axi_rresp, o_axi_rvalid,
    output i_axi_rready
  );
endinterface

// File: rtl/axi_lite_slave_bridge.sv
// AXI4-Lite slave to simple peripheral register port bridge.
// Ports: clk, resetn (async low); axi (slave modport);
// o_wr_* peripheral write strobe/addr/data/strb;
// o_rd_en/o_rd_addr read request, i_rd_data/i_rd_valid reply.
module axi_lite_slave_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LIMIT = 'h100,
  parameter int RD_TIMEOUT = 255,
  localparam int STRB_W = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  axi_lite_slave_bridge_if.slave axi,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic [STRB_W-1:0]     o_wr_strb,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_rd_valid
);
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] A_LIM =
    ADDR_WIDTH'(ADDR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT);

  localparam logic [1:0] RSP_OKAY = 2'b00;
  localparam logic [1:0] RSP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_EXEC = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  // ---------------- write path ----------------
  logic [1:0]            w_state;
  logic                  aw_got;
  logic                  w_got;
  logic [ADDR_WIDTH-1:0] aw_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [STRB_W-1:0]     ws_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  w_both;
  logic [ADDR_WIDTH-1:0] aw_cur;
  logic [DATA_WIDTH-1:0] wd_cur;
  logic [STRB_W-1:0]     ws_cur;
  logic                  w_in_rng;

  assign aw_hs = axi.i_axi_awvalid & axi.o_axi_awready;
  assign w_hs  = axi.i_axi_wvalid & axi.o_axi_wready;
  // Both channels count as captured if already held or
  // handshaking this cycle, so AW/W may arrive together.
  assign w_both = (aw_got | aw_hs) & (w_got | w_hs);
  assign aw_cur = aw_hs ? axi.i_axi_awaddr : aw_q;
  assign wd_cur = w_hs ? axi.i_axi_wdata : wd_q;
  assign ws_cur = w_hs ? axi.i_axi_wstrb : ws_q;
  assign w_in_rng = aw_cur < A_LIM;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state           <= W_IDLE;
      aw_got            <= 1'b0;
      w_got             <= 1'b0;
      aw_q              <= '0;
      wd_q              <= '0;
      ws_q              <= '0;
      axi.o_axi_awready <= 1'b0;
      axi.o_axi_wready  <= 1'b0;
      axi.o_axi_bvalid  <= 1'b0;
      axi.o_axi_bresp   <= RSP_OKAY;
      o_wr_en           <= 1'b0;
      o_wr_addr         <= '0;
      o_wr_data         <= '0;
      o_wr_strb         <= '0;
    end else begin
      o_wr_en <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_q   <= axi.i_axi_awaddr;
            aw_got <= 1'b1;
          end
          if (w_hs) begin
            wd_q  <= axi.i_axi_wdata;
            ws_q  <= axi.i_axi_wstrb;
            w_got <= 1'b1;
          end
          if (w_both) begin
            // Peripheral-side outputs change only here so they
            // stay put for the whole transaction.
            o_wr_addr         <= aw_cur;
            o_wr_data         <= wd_cur;
            o_wr_strb         <= ws_cur;
            o_wr_en           <= w_in_rng;
            axi.o_axi_bresp   <= w_in_rng ? RSP_OKAY
                                          : RSP_SLVERR;
            axi.o_axi_awready <= 1'b0;
            axi.o_axi_wready  <= 1'b0;
            w_state           <= W_EXEC;
          end else begin
            axi.o_axi_awready <= ~(aw_got | aw_hs);
            axi.o_axi_wready  <= ~(w_got | w_hs);
          end
        end
        W_EXEC: begin
          aw_got           <= 1'b0;
          w_got            <= 1'b0;
          axi.o_axi_bvalid <= 1'b1;
          w_state          <= W_RESP;
        end
        W_RESP: begin
          if (axi.i_axi_bready) begin
            axi.o_axi_bvalid  <= 1'b0;
            axi.o_axi_awready <= 1'b1;
            axi.o_axi_wready  <= 1'b1;
            w_state           <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  logic [1:0]       r_state;
  logic [CNT_W-1:0] rd_cnt;
  logic             ar_hs;

  assign ar_hs = axi.i_axi_arvalid & axi.o_axi_arready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state           <= R_IDLE;
      rd_cnt            <= '0;
      axi.o_axi_arready <= 1'b0;
      axi.o_axi_rvalid  <= 1'b0;
      axi.o_axi_rdata   <= '0;
      axi.o_axi_rresp   <= RSP_OKAY;
      o_rd_en           <= 1'b0;
      o_rd_addr         <= '0;
    end else begin
      o_rd_en <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            o_rd_addr         <= axi.i_axi_araddr;
            axi.o_axi_arready <= 1'b0;
            if (axi.i_axi_araddr < A_LIM) begin
              o_rd_en <= 1'b1;
              rd_cnt  <= '0;
              r_state <= R_WAIT;
            end else begin
              axi.o_axi_rdata  <= '0;
              axi.o_axi_rresp  <= RSP_SLVERR;
              axi.o_axi_rvalid <= 1'b1;
              r_state          <= R_RESP;
            end
          end else begin
            axi.o_axi_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          // Data arriving on the expiry cycle still wins.
          if (i_rd_valid) begin
            axi.o_axi_rdata  <= i_rd_data;
            axi.o_axi_rresp  <= RSP_OKAY;
            axi.o_axi_rvalid <= 1'b1;
            r_state          <= R_RESP;
          end else if (rd_cnt == CNT_MAX) begin
            axi.o_axi_rdata  <= '0;
            axi.o_axi_rresp  <= RSP_SLVERR;
            axi.o_axi_rvalid <= 1'b1;
            r_state          <= R_RESP;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        R_RESP: begin
          if (axi.i_axi_rready) begin
            axi.o_axi_rvalid  <= 1'b0;
            axi.o_axi_arready <= 1'b1;
            r_state           <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_slave_bridge.sv
// Directed scoreboard bench for axi_lite_slave_bridge.
// Drives/samples on the falling clock edge.
module tb_axi_lite_slave_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  axi_lite_slave_bridge_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) axi ();

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  axi_lite_slave_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ADDR_LIMIT('h100), .RD_TIMEOUT(TO)
  ) u_dut (
    .clk(clk), .resetn(resetn), .axi(axi),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .o_wr_strb(wr_strb),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr),
    .i_rd_data(rd_data), .i_rd_valid(rd_valid)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } wr_t;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    r;
  } rd_t;

  wr_t        exp_wr[$];
  logic [1:0] exp_b[$];
  rd_t        exp_r[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [AW-1:0] a);
    int n = 0;
    axi.i_axi_awaddr  = a;
    axi.i_axi_awvalid = 1'b1;
    while (!axi.o_axi_awready && n < 20) begin
      @(negedge clk); n++;
    end
    chk("aw_ready_wait", 64'(n < 20), 1);
    @(negedge clk);
    axi.i_axi_awvalid = 1'b0;
    hs_cyc = cyc;
  endtask

  task automatic send_w(input logic [DW-1:0] d,
                        input logic [SW-1:0] s);
    int n = 0;
    axi.i_axi_wdata  = d;
    axi.i_axi_wstrb  = s;
    axi.i_axi_wvalid = 1'b1;
    while (!axi.o_axi_wready && n < 20) begin
      @(negedge clk); n++;
    end
    chk("w_ready_wait", 64'(n < 20), 1);
    @(negedge clk);
    axi.i_axi_wvalid = 1'b0;
    hs_cyc = cyc;
  endtask

  task automatic send_both(input logic [AW-1:0] a,
                           input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
    int n = 0;
    axi.i_axi_awaddr  = a;
    axi.i_axi_awvalid = 1'b1;
    axi.i_axi_wdata   = d;
    axi.i_axi_wstrb   = s;
    axi.i_axi_wvalid  = 1'b1;
    while (!(axi.o_axi_awready && axi.o_axi_wready)
           && n < 20) begin
      @(negedge clk); n++;
    end
    chk("aw_w_ready_wait", 64'(n < 20), 1);
    @(negedge clk);
    axi.i_axi_awvalid = 1'b0;
    axi.i_axi_wvalid  = 1'b0;
    hs_cyc = cyc;
  endtask

  task automatic send_ar(input logic [AW-1:0] a);
    int n = 0;
    axi.i_axi_araddr  = a;
    axi.i_axi_arvalid = 1'b1;
    while (!axi.o_axi_arready && n < 20) begin
      @(negedge clk); n++;
    end
    chk("ar_ready_wait", 64'(n < 20), 1);
    @(negedge clk);
    axi.i_axi_arvalid = 1'b0;
    hs_cyc = cyc;
  endtask

  // Called on the falling edge right after the last handshake.
  task automatic chk_wexec(input string tag, input bit in_rng);
    wr_t e;
    chk({tag, "_wr_en"}, 64'(wr_en), 64'(in_rng));
    if (in_rng) begin
      e = exp_wr.pop_front();
      chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(e.a));
      chk({tag, "_wr_data"}, 64'(wr_data), 64'(e.d));
      chk({tag, "_wr_strb"}, 64'(wr_strb), 64'(e.s));
    end
  endtask

  task automatic wait_b(input string tag, input int lat,
                        input int hold);
    int n = 0;
    logic [1:0] e;
    while (!axi.o_axi_bvalid && n < 20) begin
      @(negedge clk); n++;
    end
    chk({tag, "_bvalid"}, 64'(axi.o_axi_bvalid), 1);
    if (lat >= 0)
      chk({tag, "_b_latency"}, 64'(cyc - hs_cyc), 64'(lat));
    e = exp_b.pop_front();
    chk({tag, "_bresp"}, 64'(axi.o_axi_bresp), 64'(e));
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_b_hold"},
          64'({axi.o_axi_bvalid, axi.o_axi_bresp}),
          64'({1'b1, e}));
    end
    axi.i_axi_bready = 1'b1;
    @(negedge clk);
    axi.i_axi_bready = 1'b0;
    chk({tag, "_b_drop"}, 64'(axi.o_axi_bvalid), 0);
    chk({tag, "_aw_w_ready_back"},
        64'({axi.o_axi_awready, axi.o_axi_wready}), 64'(3));
  endtask

  task automatic wait_r(input string tag, input int lat,
                        input int hold);
    int n = 0;
    rd_t e;
    while (!axi.o_axi_rvalid && n < 20) begin
      @(negedge clk); n++;
    end
    chk({tag, "_rvalid"}, 64'(axi.o_axi_rvalid), 1);
    chk({tag, "_r_latency"}, 64'(cyc - hs_cyc), 64'(lat));
    e = exp_r.pop_front();
    chk({tag, "_rdata"}, 64'(axi.o_axi_rdata), 64'(e.d));
    chk({tag, "_rresp"}, 64'(axi.o_axi_rresp), 64'(e.r));
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_r_hold"},
          {29'd0, axi.o_axi_rvalid, axi.o_axi_rdata,
           axi.o_axi_rresp},
          {29'd0, 1'b1, e.d, e.r});
    end
    axi.i_axi_rready = 1'b1;
    @(negedge clk);
    axi.i_axi_rready = 1'b0;
    chk({tag, "_r_drop"}, 64'(axi.o_axi_rvalid), 0);
    chk({tag, "_arready_back"}, 64'(axi.o_axi_arready), 1);
  endtask

  // k cycles after the o_rd_en cycle, pulse i_rd_valid.
  task automatic pulse_rd(input int k, input logic [DW-1:0] d);
    @(negedge clk);
    chk("rd_en_single", 64'(rd_en), 0);
    repeat (k - 1) @(negedge clk);
    rd_data  = d;
    rd_valid = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},
        64'({axi.o_axi_awready, axi.o_axi_wready,
             axi.o_axi_arready}), 0);
    chk({tag, "_valid"},
        64'({axi.o_axi_bvalid, axi.o_axi_rvalid,
             wr_en, rd_en}), 0);
    chk({tag, "_resp"},
        64'({axi.o_axi_bresp, axi.o_axi_rresp}), 0);
    chk({tag, "_rdata"}, 64'(axi.o_axi_rdata), 0);
    chk({tag, "_wr_bus"},
        {wr_addr, wr_data} | 64'(wr_strb), 0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 0);
  endtask

  initial begin
    axi.i_axi_awaddr  = '0;
    axi.i_axi_awvalid = 1'b0;
    axi.i_axi_wdata   = '0;
    axi.i_axi_wstrb   = '0;
    axi.i_axi_wvalid  = 1'b0;
    axi.i_axi_bready  = 1'b0;
    axi.i_axi_araddr  = '0;
    axi.i_axi_arvalid = 1'b0;
    axi.i_axi_rready  = 1'b0;
    rd_data  = '0;
    rd_valid = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset",
        64'({axi.o_axi_awready, axi.o_axi_wready,
             axi.o_axi_arready}), 64'(7));

    // single write, AW and W together
    exp_wr.push_back('{32'h10, 32'hA5A5_0001, 4'hF});
    exp_b.push_back(2'b00);
    send_both(32'h10, 32'hA5A5_0001, 4'hF);
    chk_wexec("w1", 1'b1);
    wait_b("w1", 1, 0);

    // W first, AW three cycles later, slow bready
    exp_wr.push_back('{32'h20, 32'h0BAD_F00D, 4'hC});
    exp_b.push_back(2'b00);
    send_w(32'h0BAD_F00D, 4'hC);
    chk("w2_wready_low", 64'(axi.o_axi_wready), 0);
    chk("w2_awready_high", 64'(axi.o_axi_awready), 1);
    repeat (2) @(negedge clk);
    chk("w2_wait", 64'({axi.o_axi_wready, wr_en,
                        axi.o_axi_bvalid}), 0);
    send_aw(32'h20);
    chk_wexec("w2", 1'b1);
    wait_b("w2", 1, 3);

    // last in-range address, partial strobe
    exp_wr.push_back('{32'hFC, 32'h1357_9BDF, 4'h3});
    exp_b.push_back(2'b00);
    send_both(32'hFC, 32'h1357_9BDF, 4'h3);
    chk_wexec("w3", 1'b1);
    wait_b("w3", 1, 0);

    // first out-of-range address
    exp_b.push_back(2'b10);
    send_both(32'h100, 32'hFFFF_0000, 4'hF);
    chk_wexec("w4", 1'b0);
    wait_b("w4", 1, 1);
    chk("w4_wr_addr_held", 64'(wr_addr), 64'(32'h100));

    // out-of-range read
    exp_r.push_back('{32'h0, 2'b10});
    send_ar(32'h104);
    chk("r1_rd_en", 64'(rd_en), 0);
    chk("r1_rd_addr", 64'(rd_addr), 64'(32'h104));
    wait_r("r1", 0, 0);

    // read, data 3 cycles after o_rd_en, rready late
    exp_r.push_back('{32'hDEAD_BEEF, 2'b00});
    send_ar(32'h08);
    chk("r2_rd_en", 64'(rd_en), 1);
    chk("r2_rd_addr", 64'(rd_addr), 64'(32'h08));
    pulse_rd(3, 32'hDEAD_BEEF);
    wait_r("r2", 4, 2);

    // zero-wait peripheral
    exp_r.push_back('{32'h0000_5A5A, 2'b00});
    send_ar(32'h04);
    chk("r3_rd_en", 64'(rd_en), 1);
    pulse_rd(1, 32'h0000_5A5A);
    wait_r("r3", 2, 0);

    // timeout, no reply
    exp_r.push_back('{32'h0, 2'b10});
    send_ar(32'h0C);
    chk("r4_rd_en", 64'(rd_en), 1);
    wait_r("r4", TO + 1, 1);

    // reply on the expiry cycle
    exp_r.push_back('{32'h1234_5678, 2'b00});
    send_ar(32'h0C);
    pulse_rd(TO, 32'h1234_5678);
    wait_r("r5", TO + 1, 0);

    // stray i_rd_valid while idle
    rd_data  = 32'hCAFE_CAFE;
    rd_valid = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
    @(negedge clk);
    chk("stray_rd_valid", 64'(axi.o_axi_rvalid), 0);

    // concurrent write and read
    exp_wr.push_back('{32'h30, 32'h0F0F_0F0F, 4'h5});
    exp_b.push_back(2'b00);
    exp_r.push_back('{32'h7777_0000, 2'b00});
    axi.i_axi_araddr  = 32'h34;
    axi.i_axi_arvalid = 1'b1;
    send_both(32'h30, 32'h0F0F_0F0F, 4'h5);
    axi.i_axi_arvalid = 1'b0;
    chk("cc_rd_en", 64'(rd_en), 1);
    chk_wexec("cc", 1'b1);
    pulse_rd(1, 32'h7777_0000);
    wait_r("cc", 2, 0);
    wait_b("cc", -1, 0);

    // reset in R_WAIT drops the read
    send_ar(32'h18);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("arready_after_mid_reset",
        64'(axi.o_axi_arready), 1);
    repeat (TO + 3) @(negedge clk);
    chk("no_resp_after_reset",
        64'({axi.o_axi_rvalid, axi.o_axi_bvalid}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
